// File: rtl/parametric_dual_port_memory.sv
// rtl/parametric_dual_port_memory.sv - simple dual-port RAM with byte masks, post-reset clear sweep, 1/2-cycle read pipeline
// Port A writes, port B reads; nothing is accepted until every word has been zeroed.
module parametric_dual_port_memory #(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 12,
   parameter int READ_LATENCY = 1,
   parameter int BYPASS       = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   output logic                    ready,
   input  logic                    wr_en,
   input  logic [DATA_WIDTH/8-1:0] write_mask,
   input  logic [ADDR_WIDTH-1:0]   addr_a,
   input  logic [DATA_WIDTH-1:0]   write_data,
   input  logic                    rd_en,
   input  logic [ADDR_WIDTH-1:0]   addr_b,
   output logic [DATA_WIDTH-1:0]   read_data,
   output logic                    read_valid
);
   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam int NB    = DATA_WIDTH / 8;
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};
   localparam logic [ADDR_WIDTH-1:0] ONE       = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

   if (DATA_WIDTH % 8 != 0) begin : g_bad_width
      $error("DATA_WIDTH must be a multiple of 8");
   end
   if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
      $error("READ_LATENCY must be 1 or 2");
   end

   typedef enum logic {CLEAR, READY} state_t;

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
   logic                    mem_we;
   logic [ADDR_WIDTH-1:0]   mem_addr;
   logic [DATA_WIDTH-1:0]   mem_wdata;
   logic [NB-1:0]           mem_mask;
   logic                    rd_accept;
   logic [DATA_WIDTH-1:0]   rd_word;
   logic                    s1_valid_q, s1_valid_d;
   logic [DATA_WIDTH-1:0]   s1_data_q, s1_data_d;

   // The sweep borrows the write port, so user traffic is simply not routed in CLEAR.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      mem_we    = 1'b0;
      mem_addr  = addr_a;
      mem_wdata = write_data;
      mem_mask  = write_mask;
      rd_accept = 1'b0;
      if (state_q == CLEAR) begin
         mem_we    = 1'b1;
         mem_addr  = cnt_q;
         mem_wdata = '0;
         mem_mask  = '1;
         cnt_d     = cnt_q + ONE;
         if (cnt_q == LAST_ADDR) begin
            state_d = READY;
         end
      end else begin
         mem_we    = wr_en;
         rd_accept = rd_en;
      end
   end

   assign ready = (state_q == READY);

   always_comb begin
      rd_word = mem_q[addr_b];
      if ((BYPASS != 0) && ready && wr_en && (addr_a == addr_b)) begin
         for (int i = 0; i < NB; i++) begin
            if (write_mask[i]) begin
               rd_word[8*i +: 8] = write_data[8*i +: 8];
            end
         end
      end
   end

   always_comb begin
      s1_valid_d = rd_accept;
      s1_data_d  = rd_accept ? rd_word : s1_data_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= CLEAR;
         cnt_q      <= '0;
         s1_valid_q <= 1'b0;
         s1_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         s1_valid_q <= s1_valid_d;
         s1_data_q  <= s1_data_d;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int i = 0; i < NB; i++) begin
            if (mem_mask[i]) begin
               mem_q[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
            end
         end
      end
   end

   // The second stage only re-times the captured word, so later writes cannot reach it.
   if (READ_LATENCY == 2) begin : g_lat2
      logic                  s2_valid_q, s2_valid_d;
      logic [DATA_WIDTH-1:0] s2_data_q, s2_data_d;

      always_comb begin
         s2_valid_d = s1_valid_q;
         s2_data_d  = s1_valid_q ? s1_data_q : s2_data_q;
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
         end else begin
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
         end
      end

      assign read_valid = s2_valid_q;
      assign read_data  = s2_data_q;
   end else begin : g_lat1
      assign read_valid = s1_valid_q;
      assign read_data  = s1_data_q;
   end
endmodule
